mux_nx1_skid: RTL

- Parametrised successor to the 32-bit 2:1 datapath mux.
- Selects one of NUM_INPUTS channels of WIDTH bits, registers the result, and presents it on a valid/ready interface.
- A one-entry skid buffer sustains one transfer per clock under downstream back-pressure.
- Used where a datapath select point must be retimed, e.g. writeback/forwarding source selection between pipeline stages.

---
 rtl/mux_nx1_skid.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mux_nx1_skid.sv
// -----------------------------------------------------------------------------
// mux_nx1_skid
//
// Registered N:1 datapath select with a valid/ready output interface.
// One of NUM_INPUTS channels of WIDTH bits is chosen by `select`, captured in
// an output register, and handed downstream. A one-entry skid register lets
// the block keep accepting one item per clock while downstream stalls. This
// is what allows `in_ready` to depend on registered state only.
//
// An out-of-range `select` falls back to channel 0 with effective index 0,
// and it sets the sticky `sel_err` flag when that item is accepted.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   in_bus     in   NUM_INPUTS*WIDTH flattened channels, k = in_bus[k*WIDTH +: WIDTH]
//   select     in   SEL_WIDTH channel index, sampled with in_bus on accept
//   in_valid   in   upstream offers in_bus/select
//   in_ready   out  block can accept this cycle
//   out        out  WIDTH registered selected data
//   out_sel    out  SEL_WIDTH effective index that produced out
//   out_valid  out  out/out_sel hold a valid item
//   out_ready  in   downstream consumes this cycle
//   sel_err    out  sticky: an out-of-range select was accepted
// -----------------------------------------------------------------------------
module mux_nx1_skid #(
  parameter  int WIDTH      = 32,
  parameter  int NUM_INPUTS = 4,
  localparam int SEL_WIDTH  = (NUM_INPUTS > 2) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_INPUTS*WIDTH-1:0] in_bus,
  input  logic [SEL_WIDTH-1:0]        select,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [WIDTH-1:0]            out,
  output logic [SEL_WIDTH-1:0]        out_sel,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        sel_err
);

  // Occupancy of the two-entry (output + skid) storage.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e               state, state_nxt;
  logic                 skid_valid;
  logic [WIDTH-1:0]     skid_data;
  logic [SEL_WIDTH-1:0] skid_sel;

  logic                 accept, consume;
  logic                 in_range;
  logic [WIDTH-1:0]     sel_data;
  logic [SEL_WIDTH-1:0] eff_sel;

  logic                 load_out;     // output register takes a new item
  logic                 out_from_skid;// ... and that item comes from the skid
  logic                 load_skid;    // skid register takes the incoming item

  assign out_valid  = (state != EMPTY);
  assign skid_valid = (state == FULL);

  // Ready comes from registered state (and reset) only, so there is no
  // combinational in_valid -> in_ready path through this block.
  assign in_ready = !skid_valid && !reset;
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid && out_ready;

  // Channel select. Scanning every legal index gives the channel-0 fallback
  // for free when select is out of range, with no out-of-bounds part-select.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // skips an assignment would otherwise infer a latch.
    sel_data = in_bus[WIDTH-1:0];
    eff_sel  = '0;
    in_range = 1'b0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (select == SEL_WIDTH'(k)) begin
        sel_data = in_bus[k*WIDTH +: WIDTH];
        eff_sel  = select;
        in_range = 1'b1;
      end
    end
  end

  // Next-state and register load controls.
  always_comb begin
    state_nxt     = state;
    load_out      = 1'b0;
    out_from_skid = 1'b0;
    load_skid     = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt = ONE;
          load_out  = 1'b1;
        end
      end
      ONE: begin
        if (accept && consume) begin
          load_out = 1'b1;
        end else if (accept) begin
          state_nxt = FULL;
          load_skid = 1'b1;
        end else if (consume) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only a consume can move the state.
        if (consume) begin
          state_nxt     = ONE;
          load_out      = 1'b1;
          out_from_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    if (reset) begin
      // NOTE: the data registers are reset too, not just the valid bits,
      // because out/out_sel must read 0 after reset.
      state     <= EMPTY;
      out       <= '0;
      out_sel   <= '0;
      skid_data <= '0;
      skid_sel  <= '0;
      sel_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_out) begin
        out     <= out_from_skid ? skid_data : sel_data;
        out_sel <= out_from_skid ? skid_sel  : eff_sel;
      end
      if (load_skid) begin
        skid_data <= sel_data;
        skid_sel  <= eff_sel;
      end
      if (accept && !in_range) begin
        sel_err <= 1'b1;
      end
    end
  end

endmodule
